// File: rtl/lsu_ctrl_pkg.sv
// Shared types for the load/store unit controller: FSM states, access sizes
// and the request/output bundles used by lsu_ctrl and lsu_align.
package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Size code 3 is reserved and behaves as a word access.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_ctrl_in_type;

  typedef struct packed {
    logic        req_ready;
    logic        mem_valid;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
  } lsu_ctrl_out_type;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-lane strobes and write data for both beats,
// misalignment detection, and load-result shifting/masking/extension.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata0,
  input  logic [31:0] i_rdata1,
  output logic [3:0]  o_strb0,
  output logic [3:0]  o_strb1,
  output logic [31:0] o_wdata0,
  output logic [31:0] o_wdata1,
  output logic        o_misaligned,
  output logic [31:0] o_load_data
);

  logic [3:0]  w_mask;
  logic [7:0]  w_strb64;
  logic [63:0] w_data64;
  logic [31:0] w_raw;

  always_comb begin
    w_mask = 4'hF;
    case (i_size)
      SZ_B:    w_mask = 4'h1;
      SZ_H:    w_mask = 4'h3;
      default: w_mask = 4'hF;
    endcase
  end

  assign w_strb64 = {4'b0000, w_mask} << i_off;
  assign w_data64 = {32'd0, i_wdata} << {i_off, 3'b000};
  assign w_raw    = 32'({i_rdata1, i_rdata0} >> {i_off, 3'b000});

  assign o_strb0      = w_strb64[3:0];
  assign o_strb1      = w_strb64[7:4];
  assign o_wdata0     = w_data64[31:0];
  assign o_wdata1     = w_data64[63:32];
  assign o_misaligned = |w_strb64[7:4];

  always_comb begin
    o_load_data = w_raw;
    case (i_size)
      SZ_B: o_load_data = i_unsigned ? {24'd0, w_raw[7:0]}
                                     : {{24{w_raw[7]}}, w_raw[7:0]};
      SZ_H: o_load_data = i_unsigned ? {16'd0, w_raw[15:0]}
                                     : {{16{w_raw[15]}}, w_raw[15:0]};
      default: o_load_data = w_raw;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller FSM: accepts one request, runs one or two bus beats,
// then pulses a response. Define LSU_MISALIGN_EN to split misaligned accesses.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_store,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  lsu_state_e       r_state;
  lsu_ctrl_in_type  r_req;
  logic [31:0]      r_rdata0;
  logic [31:0]      r_rdata1;
  logic             r_err;

  lsu_ctrl_in_type  w_req_in;
  lsu_ctrl_in_type  w_cur;
  lsu_ctrl_out_type w_out;
  logic             w_hs;
  logic [31:0]      w_base;
  logic [3:0]       w_strb0;
  logic [3:0]       w_strb1;
  logic [31:0]      w_wdata0;
  logic [31:0]      w_wdata1;
  logic             w_mis;
  logic [31:0]      w_load;

  assign w_req_in = '{store:       req_store,
                      size:        req_size,
                      is_unsigned: req_unsigned,
                      addr:        req_addr,
                      wdata:       req_wdata};

  // In IDLE the lane logic looks at the incoming request so the fault
  // decision can be made at the handshake; otherwise it uses the latched one.
  assign w_cur  = (r_state == ST_IDLE) ? w_req_in : r_req;
  assign w_hs   = req_valid && (r_state == ST_IDLE);
  assign w_base = {r_req.addr[31:2], 2'b00};

  lsu_align u_align (
    .i_size       (w_cur.size),
    .i_unsigned   (w_cur.is_unsigned),
    .i_off        (w_cur.addr[1:0]),
    .i_wdata      (w_cur.wdata),
    .i_rdata0     (r_rdata0),
    .i_rdata1     (r_rdata1),
    .o_strb0      (w_strb0),
    .o_strb1      (w_strb1),
    .o_wdata0     (w_wdata0),
    .o_wdata1     (w_wdata1),
    .o_misaligned (w_mis),
    .o_load_data  (w_load)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_req    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_req <= w_req_in;
`ifdef LSU_MISALIGN_EN
            r_err   <= 1'b0;
            r_state <= ST_BEAT0;
`else
            r_err   <= w_mis;
            r_state <= w_mis ? ST_RESP : ST_BEAT0;
`endif
          end
        end
        ST_BEAT0: begin
          if (mem_ready) begin
            r_rdata0 <= mem_rdata;
            r_state  <= w_mis ? ST_BEAT1 : ST_RESP;
          end
        end
        ST_BEAT1: begin
          if (mem_ready) begin
            r_rdata1 <= mem_rdata;
            r_state  <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_out           = '0;
    w_out.req_ready = (r_state == ST_IDLE);
    case (r_state)
      ST_BEAT0: begin
        w_out.mem_valid = 1'b1;
        w_out.mem_store = r_req.store;
        w_out.mem_addr  = w_base;
        w_out.mem_wstrb = w_strb0;
        w_out.mem_wdata = w_wdata0;
      end
      ST_BEAT1: begin
        w_out.mem_valid = 1'b1;
        w_out.mem_store = r_req.store;
        w_out.mem_addr  = w_base + 32'd4;
        w_out.mem_wstrb = w_strb1;
        w_out.mem_wdata = w_wdata1;
      end
      ST_RESP: begin
        w_out.rsp_valid = 1'b1;
        w_out.rsp_err   = r_err;
        w_out.rsp_data  = (r_req.store || r_err) ? '0 : w_load;
      end
      default: ;
    endcase
  end

  assign req_ready = w_out.req_ready;
  assign mem_valid = w_out.mem_valid;
  assign mem_store = w_out.mem_store;
  assign mem_addr  = w_out.mem_addr;
  assign mem_wstrb = w_out.mem_wstrb;
  assign mem_wdata = w_out.mem_wdata;
  assign rsp_valid = w_out.rsp_valid;
  assign rsp_data  = w_out.rsp_data;
  assign rsp_err   = w_out.rsp_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: driver pushes model transactions, a memory
// responder serves beats, and a monitor checks every cycle against the queue.
module tb_lsu_ctrl;

`ifdef LSU_MISALIGN_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_store;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;

  lsu_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_store(mem_store),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial forever #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  nb;
    logic        st;
    logic [31:0] a0, a1;
    logic [3:0]  s0, s1;
    logic [31:0] d0, d1;
    logic [31:0] rd;
    logic        err;
  } txn_t;

  txn_t        q[$];
  logic [31:0] rq[$];
  int unsigned n_chk = 0, n_fail = 0;
  int unsigned cyc = 0, hs_cyc = 0, last_lat = 0, n_rsp = 0, n_mv = 0, n_issued = 0;
  int unsigned rdy_mode = 0;
  logic [31:0] last_rsp;
  logic        last_err;
  logic [31:0] seen_addr[2];
  logic [3:0]  seen_strb[2];
  logic [31:0] seen_wd[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte-lane view of the access against an 8-byte window.
  function automatic txn_t model(input logic st, input logic [1:0] sz, input logic un,
                                 input logic [31:0] a, wd, r0, r1);
    txn_t t;
    int unsigned nbytes, off;
    logic [63:0] rb;
    logic [31:0] v;
    t = '0;
    t.st = st;
    off = int'(a[1:0]);
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    rb = {r1, r0};
    if (off + nbytes > 4 && !EN) begin
      t.nb = 2'd0;
      t.err = 1'b1;
      return t;
    end
    t.nb = (off + nbytes > 4) ? 2'd2 : 2'd1;
    t.a0 = {a[31:2], 2'b00};
    t.a1 = t.a0 + 32'd4;
    for (int unsigned l = 0; l < 4; l++) begin
      if (l >= off && l < off + nbytes) t.s0[l] = 1'b1;
      if (l >= off) t.d0[8*l +: 8] = wd[8*(l-off) +: 8];
      if (l + 4 < off + nbytes) t.s1[l] = 1'b1;
      if (l < off) t.d1[8*l +: 8] = wd[8*(l+4-off) +: 8];
    end
    if (!st) begin
      v = '0;
      for (int unsigned i = 0; i < nbytes; i++) v[8*i +: 8] = rb[8*(off+i) +: 8];
      if (!un && nbytes < 4 && rb[8*(off+nbytes)-1])
        for (int unsigned i = nbytes; i < 4; i++) v[8*i +: 8] = 8'hFF;
      t.rd = v;
    end
    return t;
  endfunction

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Memory responder: serves queued read data; toggles mem_ready randomly
  // outside beats to exercise the controller ignoring it.
  initial begin : responder
    bit r_fire;
    int unsigned stall;
    r_fire = 0;
    stall = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        r_fire = 0; stall = 0; mem_ready = 1'b0;
      end else begin
        if (r_fire) begin
          if (rq.size() > 0) void'(rq.pop_front());
          stall = 0;
        end
        if (mem_valid) begin
          case (rdy_mode)
            1: mem_ready = 1'b1;
            2: mem_ready = 1'b0;
            3: mem_ready = (stall >= 3);
            default: mem_ready = ($urandom % 3) != 0;
          endcase
          stall++;
          mem_rdata = (rq.size() > 0) ? rq[0] : $urandom;
          r_fire = mem_ready;
        end else begin
          mem_ready = 1'($urandom % 2);
          mem_rdata = $urandom;
          r_fire = 0;
          stall = 0;
        end
      end
    end
  end

  initial begin : monitor
    bit busy, prev_hs, due_now, due_next, prev_stall, exp_mv;
    int unsigned bi;
    logic [68:0] prev_bus;
    txn_t cur;
    busy = 0; prev_hs = 0; due_next = 0; prev_stall = 0; bi = 0; prev_bus = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        busy = 0; bi = 0; due_next = 0; prev_hs = 0; prev_stall = 0;
        continue;
      end
      due_now = due_next;
      due_next = 0;
      if (prev_hs) begin
        busy = 1;
        bi = 0;
        if (q.size() > 0 && q[0].nb == 2'd0) due_now = 1;
      end
      exp_mv = busy && q.size() > 0 && bi < int'(q[0].nb);
      chk("mem_valid", mem_valid, exp_mv);
      chk("req_ready", req_ready, !busy);
      if (mem_valid) n_mv++;
      if (mem_valid && exp_mv) begin
        cur = q[0];
        chk("mem_addr",  mem_addr,  (bi == 0) ? cur.a0 : cur.a1);
        chk("mem_wstrb", mem_wstrb, (bi == 0) ? cur.s0 : cur.s1);
        chk("mem_wdata", mem_wdata, (bi == 0) ? cur.d0 : cur.d1);
        chk("mem_store", mem_store, cur.st);
        if (prev_stall) chk("beat_stable", {mem_store, mem_addr, mem_wstrb, mem_wdata}, prev_bus);
        if (mem_ready) begin
          seen_addr[bi] = mem_addr;
          seen_strb[bi] = mem_wstrb;
          seen_wd[bi]   = mem_wdata;
          bi++;
          if (bi == int'(cur.nb)) due_next = 1;
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_bus = {mem_store, mem_addr, mem_wstrb, mem_wdata};
        end
      end else begin
        prev_stall = 0;
      end
      chk("rsp_valid", rsp_valid, due_now);
      if (rsp_valid && due_now && q.size() > 0) begin
        chk("rsp_data", rsp_data, q[0].rd);
        chk("rsp_err",  rsp_err,  q[0].err);
        last_rsp = rsp_data;
        last_err = rsp_err;
        last_lat = cyc - hs_cyc;
        void'(q.pop_front());
        busy = 0;
        n_rsp++;
      end
      prev_hs = req_valid && req_ready;
      if (prev_hs) hs_cyc = cyc;
    end
  end

  task automatic issue(input logic st, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, wd, r0, r1);
    txn_t t;
    t = model(st, sz, un, a, wd, r0, r1);
    q.push_back(t);
    if (t.nb >= 2'd1) rq.push_back(r0);
    if (t.nb == 2'd2) rq.push_back(r1);
    n_issued++;
    @(posedge clock);
    #1;
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = a; req_wdata = wd;
    for (int unsigned i = 0; i < 100; i++) begin
      @(negedge clock);
      if (req_ready) begin
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_store = 1'($urandom); req_size = 2'($urandom); req_addr = $urandom;
        return;
      end
    end
    chk("req_accept_timeout", 1, 0);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned limit);
    for (int unsigned i = 0; i < limit; i++) begin
      @(negedge clock);
      if (q.size() == 0) return;
    end
    chk("rsp_timeout", q.size(), 0);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_mem_valid"}, mem_valid, 0);
    chk({tag, "_mem_store"}, mem_store, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"},  rsp_data, 0);
    chk({tag, "_rsp_err"},   rsp_err, 0);
  endtask

  initial begin : driver
    int unsigned n0, mv0, base;
    logic [31:0] a;
    reset = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clock);
    #1 reset_check("rst");
    @(negedge clock);
    reset = 1'b1;

    // lb at 0x1003, single-cycle bus response
    rdy_mode = 1;
    issue(1'b0, 2'd0, 1'b0, 32'h0000_1003, $urandom, 32'h80FF_0000, 32'h0);
    wait_idle(50);
    chk("lb_wstrb", seen_strb[0], 4'h8);
    chk("lb_data", last_rsp, 32'hFFFF_FF80);
    chk("lb_latency", last_lat, 2);

    // sh at 0x2002
    issue(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h1234_ABCD, $urandom, $urandom);
    wait_idle(50);
    chk("sh_wstrb", seen_strb[0], 4'hC);
    chk("sh_wdata_hi", seen_wd[0][31:16], 16'hABCD);
    chk("sh_rsp_data", last_rsp, 0);

    // three-cycle backpressure on a word store
    rdy_mode = 3;
    n0 = n_rsp;
    issue(1'b1, 2'd2, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, $urandom, $urandom);
    wait_idle(50);
    chk("bp_latency", last_lat, 5);
    chk("bp_rsp_count", n_rsp - n0, 1);
    chk("bp_wdata", seen_wd[0], 32'hDEAD_BEEF);

    // lw at 0xFFFF_FFFE crossing the top of the address space
    rdy_mode = 1;
    mv0 = n_mv;
    issue(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, $urandom, 32'hAAAA_0000, 32'h0000_BBBB);
    wait_idle(50);
`ifdef LSU_MISALIGN_EN
    chk("mis_addr0", seen_addr[0], 32'hFFFF_FFFC);
    chk("mis_strb0", seen_strb[0], 4'hC);
    chk("mis_addr1", seen_addr[1], 32'h0000_0000);
    chk("mis_strb1", seen_strb[1], 4'h3);
    chk("mis_data", last_rsp, 32'hBBBB_AAAA);
    chk("mis_err", last_err, 0);
`else
    chk("mis_err", last_err, 1);
    chk("mis_data", last_rsp, 0);
    chk("mis_latency", last_lat, 1);
    chk("mis_no_beats", n_mv - mv0, 0);
`endif

    // lhu at 0x0003
    mv0 = n_mv;
    issue(1'b0, 2'd1, 1'b1, 32'h0000_0003, $urandom, 32'h1100_0000, 32'h0000_0022);
    wait_idle(50);
`ifdef LSU_MISALIGN_EN
    chk("lhu_err", last_err, 0);
    chk("lhu_data", last_rsp, 32'h0000_2211);
    chk("lhu_latency", last_lat, 3);
`else
    chk("lhu_err", last_err, 1);
    chk("lhu_latency", last_lat, 1);
    chk("lhu_no_beats", n_mv - mv0, 0);
`endif

    // reset while a beat is outstanding
    rdy_mode = 2;
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0000, $urandom, 32'h0000_00FF, 32'h0);
    begin : wait_beat
      for (int unsigned i = 0; i < 20; i++) begin
        @(negedge clock);
        if (mem_valid) disable wait_beat;
      end
      chk("abort_beat_timeout", 1, 0);
    end
    #2 reset = 1'b0;
    #1 reset_check("abort");
    q.delete();
    rq.delete();
    n0 = n_rsp;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("abort_no_rsp", n_rsp - n0, 0);
    rdy_mode = 1;
    issue(1'b0, 2'd0, 1'b1, 32'h0000_0000, $urandom, 32'h0000_00FF, 32'h0);
    wait_idle(50);
    chk("abort_lbu_data", last_rsp, 32'h0000_00FF);

    // randomized traffic with random bus stalls
    base = n_rsp;
    n_issued = 0;
    for (int unsigned k = 0; k < 300; k++) begin
      rdy_mode = ($urandom % 8 == 0) ? 1 : 0;
      a = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16)) : $urandom;
      issue(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom, $urandom);
      repeat ($urandom % 3) @(posedge clock);
    end
    wait_idle(200);
    chk("random_rsp_count", n_rsp - base, n_issued);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
